// File: rtl/obj_affine_pkg.sv
// rtl/obj_affine_pkg.sv - shared state type, default widths and accumulator sizing for the affine walker
package obj_affine_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        SUM  = 2'd2,
        WALK = 2'd3
    } state_t;

    localparam int DEF_PARAM_W = 16;
    localparam int DEF_FRAC_W  = 8;
    localparam int DEF_DIST_W  = 9;
    localparam int DEF_COORD_W = 6;
    localparam int DEF_CNT_W   = 9;

    // Two products plus a bias need two guard bits above a single product.
    function automatic int acc_w(input int param_w, input int dist_w);
        return param_w + dist_w + 2;
    endfunction

endpackage

// File: rtl/obj_affine_mac.sv
// rtl/obj_affine_mac.sv - registered two-product signed multiply-add with integer bias for one axis
module obj_affine_mac
    import obj_affine_pkg::*;
#(
    parameter int PARAM_W = DEF_PARAM_W,
    parameter int DIST_W  = DEF_DIST_W,
    parameter int COORD_W = DEF_COORD_W,
    parameter int FRAC_W  = DEF_FRAC_W,
    parameter int ACC_W   = acc_w(DEF_PARAM_W, DEF_DIST_W)
) (
    input  logic                      clock,
    input  logic                      reset_L,
    input  logic                      mul_en,
    input  logic signed [PARAM_W-1:0] ka,
    input  logic signed [PARAM_W-1:0] kb,
    input  logic signed [DIST_W-1:0]  da,
    input  logic signed [DIST_W-1:0]  db,
    input  logic        [COORD_W-1:0] bias,
    output logic signed [ACC_W-1:0]   sum
);

    localparam int PROD_W = PARAM_W + DIST_W;

    logic signed [PROD_W-1:0] prod_a;
    logic signed [PROD_W-1:0] prod_b;

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            prod_a <= '0;
            prod_b <= '0;
        end else if (mul_en) begin
            prod_a <= PROD_W'(ka) * PROD_W'(da);
            prod_b <= PROD_W'(kb) * PROD_W'(db);
        end
    end

    // Bias is an unsigned integer texel offset placed at the binary point.
    assign sum = ACC_W'(prod_a) + ACC_W'(prod_b) + (ACC_W'(bias) << FRAC_W);

endmodule

// File: rtl/obj_affine_walker.sv
// rtl/obj_affine_walker.sv - span walker stepping an affine texel coordinate one pixel per cycle
module obj_affine_walker
    import obj_affine_pkg::*;
#(
    parameter int PARAM_W = DEF_PARAM_W,
    parameter int FRAC_W  = DEF_FRAC_W,
    parameter int DIST_W  = DEF_DIST_W,
    parameter int COORD_W = DEF_COORD_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic                      clock,
    input  logic                      reset_L,
    input  logic                      start_valid,
    output logic                      start_ready,
    input  logic signed [PARAM_W-1:0] pa,
    input  logic signed [PARAM_W-1:0] pb,
    input  logic signed [PARAM_W-1:0] pc,
    input  logic signed [PARAM_W-1:0] pd,
    input  logic signed [DIST_W-1:0]  dx0,
    input  logic signed [DIST_W-1:0]  dy,
    input  logic        [COORD_W-1:0] x_bias,
    input  logic        [COORD_W-1:0] y_bias,
    input  logic        [CNT_W-1:0]   span_len,
    input  logic                      wrap_en,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic        [COORD_W-1:0] tx,
    output logic        [COORD_W-1:0] ty,
    output logic                      transparent,
    output logic                      last
);

    localparam int ACC_W = acc_w(PARAM_W, DIST_W);
    localparam int INT_HI = FRAC_W + COORD_W;

    state_t state, state_nx;

    logic signed [PARAM_W-1:0] pa_r, pb_r, pc_r, pd_r;
    logic signed [DIST_W-1:0]  dx0_r, dy_r;
    logic        [COORD_W-1:0] x_bias_r, y_bias_r;
    logic        [CNT_W-1:0]   len_r, cnt;
    logic                      wrap_r;
    logic signed [ACC_W-1:0]   acc_x, acc_y, sum_x, sum_y;
    logic                      accept, mul_en, load, step;

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (flush) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    if (start_valid) state_nx = MUL;
                MUL:     state_nx = SUM;
                SUM:     state_nx = (len_r != '0) ? WALK : IDLE;
                WALK:    if (out_ready && last) state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // flush outranks both span acceptance and the pixel handshake.
    always_comb begin
        start_ready = (state == IDLE);
        out_valid   = (state == WALK);
        mul_en      = (state == MUL);
        accept      = start_ready & start_valid & ~flush;
        load        = (state == SUM) & ~flush;
        step        = out_valid & out_ready & ~flush;
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            pa_r     <= '0;
            pb_r     <= '0;
            pc_r     <= '0;
            pd_r     <= '0;
            dx0_r    <= '0;
            dy_r     <= '0;
            x_bias_r <= '0;
            y_bias_r <= '0;
            len_r    <= '0;
            wrap_r   <= 1'b0;
        end else if (accept) begin
            pa_r     <= pa;
            pb_r     <= pb;
            pc_r     <= pc;
            pd_r     <= pd;
            dx0_r    <= dx0;
            dy_r     <= dy;
            x_bias_r <= x_bias;
            y_bias_r <= y_bias;
            len_r    <= span_len;
            wrap_r   <= wrap_en;
        end
    end

    obj_affine_mac #(
        .PARAM_W(PARAM_W), .DIST_W(DIST_W), .COORD_W(COORD_W), .FRAC_W(FRAC_W), .ACC_W(ACC_W)
    ) u_mac_x (
        .clock(clock), .reset_L(reset_L), .mul_en(mul_en),
        .ka(pa_r), .kb(pb_r), .da(dx0_r), .db(dy_r), .bias(x_bias_r), .sum(sum_x)
    );

    obj_affine_mac #(
        .PARAM_W(PARAM_W), .DIST_W(DIST_W), .COORD_W(COORD_W), .FRAC_W(FRAC_W), .ACC_W(ACC_W)
    ) u_mac_y (
        .clock(clock), .reset_L(reset_L), .mul_en(mul_en),
        .ka(pc_r), .kb(pd_r), .da(dx0_r), .db(dy_r), .bias(y_bias_r), .sum(sum_y)
    );

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            acc_x <= '0;
            acc_y <= '0;
            cnt   <= '0;
        end else if (load) begin
            acc_x <= sum_x;
            acc_y <= sum_y;
            cnt   <= len_r;
        end else if (step) begin
            acc_x <= acc_x + ACC_W'(pa_r);
            acc_y <= acc_y + ACC_W'(pc_r);
            cnt   <= cnt - CNT_W'(1);
        end
    end

    // Outputs decode straight from registers, so backpressure holds them stable.
    assign tx          = acc_x[INT_HI-1:FRAC_W];
    assign ty          = acc_y[INT_HI-1:FRAC_W];
    assign transparent = ~wrap_r & ((|acc_x[ACC_W-1:INT_HI]) | (|acc_y[ACC_W-1:INT_HI]));
    assign last        = (cnt == CNT_W'(1));

endmodule

// File: tb/tb_obj_affine_walker.sv
// tb/tb_obj_affine_walker.sv - self-checking bench for obj_affine_walker against an arithmetic span model
module tb_obj_affine_walker;

    logic               clock;
    logic               reset_L;
    logic               start_valid;
    logic               start_ready;
    logic signed [15:0] pa, pb, pc, pd;
    logic signed [8:0]  dx0, dy;
    logic        [5:0]  x_bias, y_bias;
    logic        [8:0]  span_len;
    logic               wrap_en;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    logic        [5:0]  tx, ty;
    logic               transparent;
    logic               last;

    int checks = 0;
    int errors = 0;

    int m_pa, m_pb, m_pc, m_pd, m_dx0, m_dy, m_xb, m_yb, m_len;
    bit m_wrap;

    obj_affine_walker dut (
        .clock(clock), .reset_L(reset_L),
        .start_valid(start_valid), .start_ready(start_ready),
        .pa(pa), .pb(pb), .pc(pc), .pd(pd),
        .dx0(dx0), .dy(dy), .x_bias(x_bias), .y_bias(y_bias),
        .span_len(span_len), .wrap_en(wrap_en), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .tx(tx), .ty(ty), .transparent(transparent), .last(last)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_span(input int a, input int b, input int c, input int d, input int x0,
                            input int y0, input int xb, input int yb, input int len, input bit wr);
        m_pa = a; m_pb = b; m_pc = c; m_pd = d; m_dx0 = x0; m_dy = y0;
        m_xb = xb; m_yb = yb; m_len = len; m_wrap = wr;
        pa = m_pa[15:0]; pb = m_pb[15:0]; pc = m_pc[15:0]; pd = m_pd[15:0];
        dx0 = m_dx0[8:0]; dy = m_dy[8:0];
        x_bias = m_xb[5:0]; y_bias = m_yb[5:0];
        span_len = m_len[8:0]; wrap_en = m_wrap;
    endtask

    // Texel position of pixel k in real fixed-point arithmetic (8 fractional bits).
    function automatic longint texel(input int k, input bit y_axis);
        longint v;
        if (y_axis) v = longint'(m_pc) * m_dx0 + longint'(m_pd) * m_dy + longint'(m_yb) * 256 + longint'(k) * m_pc;
        else        v = longint'(m_pa) * m_dx0 + longint'(m_pb) * m_dy + longint'(m_xb) * 256 + longint'(k) * m_pa;
        return v >>> 8;
    endfunction

    task automatic run_span(input int stall_at, input int stall_n, input int flush_at, input bit rnd_ready);
        int k, stalled, budget;
        longint ix, iy;
        bit exp_tr;
        start_valid = 1'b1;
        chk("start_ready_idle", 64'(start_ready), 64'(1));
        tick();
        start_valid = 1'b0;
        pa = 16'($urandom); pc = 16'($urandom); dx0 = 9'($urandom);
        span_len = 9'($urandom); wrap_en = 1'($urandom); x_bias = 6'($urandom);
        chk("mul_busy", 64'(start_ready), 64'(0));
        chk("mul_valid", 64'(out_valid), 64'(0));
        tick();
        chk("sum_valid", 64'(out_valid), 64'(0));
        tick();
        if (m_len == 0) begin
            chk("zero_len_valid", 64'(out_valid), 64'(0));
            chk("zero_len_idle", 64'(start_ready), 64'(1));
            return;
        end
        k = 0; stalled = 0; budget = 0;
        while (k < m_len && budget < 8 * m_len + 20) begin
            budget++;
            ix = texel(k, 1'b0);
            iy = texel(k, 1'b1);
            exp_tr = !m_wrap && (ix < 0 || ix > 63 || iy < 0 || iy > 63);
            chk("out_valid", 64'(out_valid), 64'(1));
            chk("tx", 64'(tx), 64'(ix & 63));
            chk("ty", 64'(ty), 64'(iy & 63));
            chk("transparent", 64'(transparent), 64'(exp_tr));
            chk("last", 64'(last), 64'(k == m_len - 1));
            if (k == flush_at) begin
                flush = 1'b1;
                out_ready = 1'b1;
                tick();
                flush = 1'b0;
                chk("flush_valid", 64'(out_valid), 64'(0));
                chk("flush_ready", 64'(start_ready), 64'(1));
                return;
            end
            if (k == stall_at && stalled < stall_n) begin
                out_ready = 1'b0;
                stalled++;
            end else begin
                out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            tick();
            if (out_ready) k++;
        end
        out_ready = 1'b1;
        chk("span_count", 64'(k), 64'(m_len));
        chk("end_valid", 64'(out_valid), 64'(0));
        chk("end_idle", 64'(start_ready), 64'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_L = 1'b0; start_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        set_span(0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
        #1;
        chk("rst_valid", 64'(out_valid), 64'(0));
        chk("rst_ready", 64'(start_ready), 64'(1));
        chk("rst_tx", 64'(tx), 64'(0));
        chk("rst_ty", 64'(ty), 64'(0));
        chk("rst_transparent", 64'(transparent), 64'(0));
        chk("rst_last", 64'(last), 64'(0));
        #11;
        reset_L = 1'b1;
        tick();

        set_span(256, 0, 0, 256, -8, -8, 8, 8, 16, 1'b0);   // identity
        run_span(-1, 0, -1, 1'b0);
        set_span(128, 0, 0, 256, -8, -8, 8, 8, 16, 1'b0);   // half scale
        run_span(-1, 0, -1, 1'b0);
        set_span(512, 0, 0, 256, -8, -8, 8, 8, 16, 1'b0);   // clipping
        run_span(-1, 0, -1, 1'b0);
        set_span(512, 0, 0, 256, -8, -8, 8, 8, 16, 1'b1);   // wrap
        run_span(-1, 0, -1, 1'b0);
        set_span(256, 0, 0, 256, -8, -8, 8, 8, 16, 1'b0);   // backpressure
        run_span(5, 3, -1, 1'b0);
        set_span(256, 0, 0, 256, -8, -8, 8, 8, 16, 1'b0);   // flush mid-span
        run_span(-1, 0, 7, 1'b0);
        set_span(256, 0, 0, 256, -8, -8, 8, 8, 4, 1'b0);    // clean restart after flush
        run_span(-1, 0, -1, 1'b0);
        set_span(256, 0, 0, 256, -8, -8, 8, 8, 0, 1'b0);    // zero length
        run_span(-1, 0, -1, 1'b0);

        set_span(256, 0, 0, 256, -8, -8, 8, 8, 4, 1'b0);    // flush with start in IDLE
        start_valid = 1'b1;
        flush = 1'b1;
        tick();
        start_valid = 1'b0;
        flush = 1'b0;
        chk("flush_idle_ready", 64'(start_ready), 64'(1));
        tick();
        chk("flush_idle_valid1", 64'(out_valid), 64'(0));
        tick();
        chk("flush_idle_valid2", 64'(out_valid), 64'(0));
        chk("flush_idle_ready2", 64'(start_ready), 64'(1));

        for (int n = 0; n < 12; n++) begin
            set_span(int'($urandom_range(0, 1023)) - 512, int'($urandom_range(0, 1023)) - 512,
                     int'($urandom_range(0, 1023)) - 512, int'($urandom_range(0, 1023)) - 512,
                     int'($urandom_range(0, 127)) - 64, int'($urandom_range(0, 127)) - 64,
                     int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
                     int'($urandom_range(1, 20)), 1'($urandom));
            run_span(int'($urandom_range(0, 19)), int'($urandom_range(0, 3)), -1, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/obj_affine_walker.md
# obj_affine_walker

Pipelined, parametrised successor to the combinational OBJ rot/scale unit. One setup per span computes the starting texel coordinate with multiplies. Each further pixel then steps the coordinate incrementally (+pa, +pc), emitting one texel coordinate per cycle over a valid/ready stream. Adds a wrap mode for affine BG layers, and sits between the OBJ/BG scanline sequencer and the tile-fetch stage.

## Interface
Parameters:
- PARAM_W, 16: signed fixed-point width of pa/pb/pc/pd.
- FRAC_W, 8: fractional bits of parameters and accumulators.
- DIST_W, 9: signed width of dx0/dy.
- COORD_W, 6: integer texel coordinate width (6 for OBJ ≤64, 10 for BG 1024).
- CNT_W, 9: span length counter width.

Ports:
- clock, in, 1: sole clock.
- reset_L, in, 1: asynchronous, active-low reset.
- start_valid, in, 1: span request valid.
- start_ready, out, 1: high only in IDLE.
- pa, pb, pc, pd, in, PARAM_W each: affine matrix, signed.
- dx0, dy, in, DIST_W each: signed offset of first pixel from centre.
- x_bias, y_bias, in, COORD_W each: integer centre offset.
- span_len, in, CNT_W: pixels to emit.
- wrap_en, in, 1: 1 = wrap coordinates; 0 = out-of-range marks transparent.
- flush, in, 1: synchronous abort.
- out_valid, out, 1: coordinate valid.
- out_ready, in, 1: consumer accepts.
- tx, ty, out, COORD_W each: texel coordinate.
- transparent, out, 1: coordinate is outside the texture (wrap_en=0 only).
- last, out, 1: final pixel of span.

## Operation
- Accumulator width ACC_W = PARAM_W + DIST_W + 2, signed, FRAC_W fractional bits. All math is two's complement, sign-extended to ACC_W, and never saturates.
- States IDLE → MUL → SUM → WALK → IDLE.
- IDLE: start_ready=1. On start_valid, all span inputs are latched into registers and the FSM goes to MUL. Inputs are don't-care afterwards.
- MUL: registers pa·dx0, pb·dy, pc·dx0 and pd·dy.
- SUM: loads the accumulators:
  - acc_x = pa·dx0 + pb·dy + (x_bias << FRAC_W)
  - acc_y = pc·dx0 + pd·dy + (y_bias << FRAC_W)
  - cnt loads span_len.
  - Goes to WALK if span_len≠0, otherwise to IDLE with no output.
- WALK: out_valid=1.
  - tx = acc_x[FRAC_W+COORD_W-1:FRAC_W]; ty is taken the same way from acc_y.
  - transparent = ~wrap_en & (any acc bit ≥ FRAC_W+COORD_W set, including sign), evaluated per axis and ORed.
  - last = (cnt==1).
  - On out_valid&out_ready: acc_x += pa, acc_y += pc, cnt -= 1. If last, go to IDLE.
- Backpressure: while out_valid&~out_ready, tx/ty/transparent/last are held stable and no state advances.
- flush: from any state, the next edge forces IDLE. It drops out_valid and discards the span. flush wins over a simultaneous handshake. flush in IDLE together with start_valid means the span is not accepted.
- Wrap mode: coordinates are simply truncated mod 2^COORD_W, and transparent is constant 0.

## Timing
- Reset (reset_L=0, async): state=IDLE, acc/cnt=0, out_valid=0, tx=ty=0, transparent=0, last=0, start_ready=1.
- Start accepted at edge E0. First out_valid is high after E2, i.e. setup latency is 2 cycles.
- Throughput is 1 pixel/cycle with out_ready held high. A span of N pixels occupies N+2 cycles from E0.
- After the edge accepting the last pixel, the FSM is in IDLE. The next start can be accepted no earlier than the following edge, giving one bubble cycle.
- Outputs are registered or decoded from registered state. There is no combinational path from out_ready to out_valid/tx/ty.

## Structure
- Package obj_affine_pkg: state enum (IDLE, MUL, SUM, WALK), default parameter values, and an ACC_W helper function.
- Sub-module obj_affine_mac: registered two-product signed multiply-add plus bias. It is instantiated twice, once for x and once for y, and covers the MUL and SUM stages.

## Test plan
- Identity: pa=pd=0x0100, pb=pc=0, x_bias=y_bias=8, dx0=dy=-8, len=16 → tx=0..15, ty=0, none transparent, last only on the 16th pixel, first valid 2 cycles after acceptance.
- Half scale: pa=0x0080, other inputs as identity → tx=4,4,5,5,…,11,11.
- Clipping: pa=0x0200, wrap_en=0 → pixels 0–3 (x=-8,-6,-4,-2) transparent. Pixel 4 gives tx=0 with transparent=0.
- Wrap: same inputs as Clipping with wrap_en=1 → tx=56,58,60,62,0,2,…, transparent never set.
- Backpressure: out_ready low for 3 cycles at pixel 5 → pixel 5 outputs held stable, then continuation with no skip and no duplicate. Total accepted = len.
- Flush and zero length: flush at pixel 7 → out_valid=0 and start_ready=1 the next cycle, and the new span starts cleanly. span_len=0 → no out_valid, IDLE 2 cycles after acceptance.
